// File: rtl/grf_mp.sv
// Multi-port general register file with a per-register busy scoreboard for the pipelined MIPS core.
// Register 0 always reads as zero and is never busy; the highest write-port index wins on collisions.
module grf_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1,
    parameter int BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic [(2**ADDR_W)-1:0]   busy_vec
);

    localparam int NREG = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};

    logic [DATA_W-1:0] regs_r [NREG];
    logic [NREG-1:0]   busy_r;
    logic [NREG-1:0]   set_vec_s;
    logic [NREG-1:0]   clr_vec_s;
    logic [NREG-1:0]   busy_nxt_s;

    // Decode issue/writeback strobes; an issue overrides a same-cycle clear since a newer producer is pending.
    always_comb begin
        set_vec_s = {NREG{1'b0}};
        clr_vec_s = {NREG{1'b0}};
        set_vec_s[iss_addr] = iss_en;
        for (int j = 0; j < NUM_WR; j++) begin
            clr_vec_s[wr_addr[j*ADDR_W +: ADDR_W]] = clr_vec_s[wr_addr[j*ADDR_W +: ADDR_W]] | wr_en[j];
        end
        busy_nxt_s    = (busy_r & ~clr_vec_s) | set_vec_s;
        busy_nxt_s[0] = 1'b0;
    end

    // Register array update; later ports overwrite earlier ones when addresses collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                regs_r[r] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] != ZERO_ADDR)) begin
                    regs_r[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Busy scoreboard state.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= {NREG{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    assign busy_vec = busy_r;

    // Combinational read ports; a forwarded write also masks the busy flag of the port it feeds.
    always_comb begin : read_ports
        logic [ADDR_W-1:0] a_s;
        logic [DATA_W-1:0] val_s;
        logic              hit_s;
        logic              match_s;
        rd_data = {(NUM_RD*DATA_W){1'b0}};
        rd_busy = {NUM_RD{1'b0}};
        a_s     = ZERO_ADDR;
        val_s   = {DATA_W{1'b0}};
        hit_s   = 1'b0;
        match_s = 1'b0;
        for (int k = 0; k < NUM_RD; k++) begin
            a_s   = rd_addr[k*ADDR_W +: ADDR_W];
            val_s = regs_r[a_s];
            hit_s = 1'b0;
            for (int j = 0; j < NUM_WR; j++) begin
                match_s = (BYPASS != 0) && wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == a_s);
                val_s   = match_s ? wr_data[j*DATA_W +: DATA_W] : val_s;
                hit_s   = hit_s | match_s;
            end
            rd_data[k*DATA_W +: DATA_W] = (a_s == ZERO_ADDR) ? {DATA_W{1'b0}} : val_s;
            rd_busy[k]                  = busy_r[a_s] & ~hit_s;
        end
    end

endmodule

// File: tb/tb_grf_mp.sv
// Scoreboard bench for grf_mp: two write ports, one instance with bypass and one without, sharing stimulus.
module tb_grf_mp;

    localparam int K_RD0 = 0, K_RD1 = 1, K_RB0 = 2, K_RB1 = 3, K_BV = 4;
    localparam int K_NB_RD0 = 5, K_NB_RB0 = 6, K_NB_BV = 7;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data, rd_data_nb;
    logic [1:0]  rd_busy, rd_busy_nb;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic [31:0] busy_vec, busy_vec_nb;

    typedef struct {
        int          kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    grf_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
        .iss_addr(iss_addr), .busy_vec(busy_vec)
    );

    grf_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
        .iss_addr(iss_addr), .busy_vec(busy_vec_nb)
    );

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            K_RD0:    return rd_data[31:0];
            K_RD1:    return rd_data[63:32];
            K_RB0:    return {31'd0, rd_busy[0]};
            K_RB1:    return {31'd0, rd_busy[1]};
            K_BV:     return busy_vec;
            K_NB_RD0: return rd_data_nb[31:0];
            K_NB_RB0: return {31'd0, rd_busy_nb[0]};
            K_NB_BV:  return busy_vec_nb;
            default:  return 32'hxxxx_xxxx;
        endcase
    endfunction

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 7));
        else return 5'($urandom_range(0, 31));
    endfunction

    task automatic push(input int kind, input logic [31:0] val, input string name);
        sb_q.push_back('{kind, val, name});
    endtask

    task automatic idle();
        reset    = 1'b0;
        wr_en    = 2'b00;
        wr_addr  = 10'd0;
        wr_data  = 64'd0;
        iss_en   = 1'b0;
        iss_addr = 5'd0;
        rd_addr  = 10'd0;
    endtask

    task automatic set_wr(input int j, input logic en, input logic [4:0] a, input logic [31:0] d);
        wr_en[j]            = en;
        wr_addr[j*5 +: 5]   = a;
        wr_data[j*32 +: 32] = d;
    endtask

    task automatic set_rd(input int k, input logic [4:0] a);
        rd_addr[k*5 +: 5] = a;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            idle();
            reset = (c < 2);
            if (c == 2) begin
                set_rd(0, 5'd1);
                set_rd(1, 5'd31);
                push(K_RD0, 32'd0, "reset_rd0");
                push(K_RD1, 32'd0, "reset_rd1");
                push(K_RB0, 32'd0, "reset_rb0");
                push(K_BV, 32'd0, "reset_busy_vec");
                push(K_NB_BV, 32'd0, "reset_busy_vec_nb");
            end
            #1;
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_checks++;
                if (observe(e.kind) !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", e.name, observe(e.kind), e.val);
                end
            end
        end
    endtask

    task automatic test_sweep_reset();
        exp_t e;
        for (int c = 1; c < 50; c++) begin
            @(negedge clk);
            idle();
            if (c < 32) begin
                set_wr(0, 1'b1, 5'(c), 32'h1000_0000 + 32'(c));
                iss_en   = 1'b1;
                iss_addr = 5'(c);
            end else if (c == 32) begin
                set_rd(0, 5'd1);
                set_rd(1, 5'd31);
                push(K_RD0, 32'h1000_0001, "sweep_r1");
                push(K_RD1, 32'h1000_001F, "sweep_r31");
                push(K_NB_RD0, 32'h1000_0001, "sweep_r1_nb");
                push(K_RB0, 32'd1, "sweep_busy_r1");
                push(K_BV, 32'hFFFF_FFFE, "sweep_busy_vec");
            end else if (c == 33) begin
                reset = 1'b1;
                set_wr(0, 1'b1, 5'd5, 32'hFFFF_FFFF);
            end else begin
                set_rd(0, 5'(2 * (c - 34)));
                set_rd(1, 5'(2 * (c - 34) + 1));
                push(K_RD0, 32'd0, "sweep_reset_rd0");
                push(K_RD1, 32'd0, "sweep_reset_rd1");
                push(K_RB0, 32'd0, "sweep_reset_rb0");
                push(K_BV, 32'd0, "sweep_reset_busy_vec");
            end
            #1;
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_checks++;
                if (observe(e.kind) !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", e.name, observe(e.kind), e.val);
                end
            end
        end
    endtask

    task automatic test_zero_reg();
        exp_t e;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            idle();
            if (c == 0) begin
                set_wr(0, 1'b1, 5'd0, 32'hDEAD_BEEF);
                iss_en = 1'b1;
            end
            push(K_RD0, 32'd0, "zero_rd");
            push(K_RB0, 32'd0, "zero_busy");
            push(K_NB_RD0, 32'd0, "zero_rd_nb");
            push(K_BV, 32'd0, "zero_busy_vec");
            #1;
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_checks++;
                if (observe(e.kind) !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", e.name, observe(e.kind), e.val);
                end
            end
        end
    endtask

    task automatic test_bypass();
        exp_t e;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            idle();
            if (c < 2) begin
                set_rd(0, 5'd7);
                if (c == 0) begin
                    set_wr(0, 1'b1, 5'd7, 32'h1111_1111);
                    set_wr(1, 1'b1, 5'd7, 32'h2222_2222);
                end
                push(K_RD0, 32'h2222_2222, "bypass_prio_r7");
                push(K_NB_RD0, (c == 0) ? 32'd0 : 32'h2222_2222, "nobypass_r7");
            end else begin
                set_rd(0, 5'd8);
                set_rd(1, 5'd10);
                if (c == 2) begin
                    set_wr(0, 1'b1, 5'd8, 32'h0808_0808);
                    set_wr(1, 1'b1, 5'd10, 32'h0A0A_0A0A);
                end
                push(K_RD0, 32'h0808_0808, "bypass_dual_r8");
                push(K_RD1, 32'h0A0A_0A0A, "bypass_dual_r10");
                push(K_NB_RD0, (c == 2) ? 32'd0 : 32'h0808_0808, "nobypass_r8");
            end
            #1;
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_checks++;
                if (observe(e.kind) !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", e.name, observe(e.kind), e.val);
                end
            end
        end
    endtask

    task automatic test_scoreboard();
        exp_t e;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            idle();
            set_rd(0, 5'd9);
            case (c)
                0: begin
                    iss_en   = 1'b1;
                    iss_addr = 5'd9;
                    push(K_RB0, 32'd0, "sb_issue_same_cycle");
                    push(K_BV, 32'd0, "sb_vec_c0");
                end
                1, 2: begin
                    push(K_RB0, 32'd1, "sb_busy_pending");
                    push(K_BV, 32'h0000_0200, "sb_vec_pending");
                    push(K_NB_RB0, 32'd1, "sb_busy_pending_nb");
                end
                3: begin
                    set_wr(0, 1'b1, 5'd9, 32'h0000_0055);
                    push(K_RB0, 32'd0, "sb_wb_bypass_busy");
                    push(K_RD0, 32'h0000_0055, "sb_wb_bypass_data");
                    push(K_NB_RB0, 32'd1, "sb_wb_busy_nb");
                    push(K_NB_RD0, 32'd0, "sb_wb_data_nb");
                end
                default: begin
                    push(K_BV, 32'd0, "sb_vec_cleared");
                    push(K_RB0, 32'd0, "sb_busy_cleared");
                    push(K_RD0, 32'h0000_0055, "sb_data_after");
                    push(K_NB_RD0, 32'h0000_0055, "sb_data_after_nb");
                end
            endcase
            #1;
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_checks++;
                if (observe(e.kind) !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", e.name, observe(e.kind), e.val);
                end
            end
        end
    endtask

    task automatic test_issue_clear();
        exp_t e;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            idle();
            set_rd(0, 5'd12);
            if (c == 0 || c == 2) begin
                iss_en   = 1'b1;
                iss_addr = 5'd12;
            end
            if (c == 1) begin
                push(K_RB0, 32'd1, "ic_busy_before");
            end else if (c == 2) begin
                set_wr(1, 1'b1, 5'd12, 32'h0000_ABCD);
                push(K_RD0, 32'h0000_ABCD, "ic_bypass_data");
                push(K_RB0, 32'd0, "ic_bypass_busy");
                push(K_NB_RB0, 32'd1, "ic_busy_nb");
            end else if (c == 3) begin
                push(K_RD0, 32'h0000_ABCD, "ic_data_after");
                push(K_RB0, 32'd1, "ic_busy_after");
                push(K_BV, 32'h0000_1000, "ic_vec_after");
                push(K_NB_BV, 32'h0000_1000, "ic_vec_after_nb");
            end
            #1;
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_checks++;
                if (observe(e.kind) !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", e.name, observe(e.kind), e.val);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            idle();
            case (c)
                0: begin
                    iss_en   = 1'b1;
                    iss_addr = 5'd3;
                    set_wr(0, 1'b1, 5'd3, 32'h0000_0077);
                end
                1: begin
                    set_rd(0, 5'd3);
                    push(K_RD0, 32'h0000_0077, "rm_r3_before");
                    push(K_RB0, 32'd1, "rm_r3_busy_before");
                    push(K_BV, 32'h0000_1008, "rm_vec_before");
                end
                2: begin
                    reset    = 1'b1;
                    iss_en   = 1'b1;
                    iss_addr = 5'd4;
                    set_wr(0, 1'b1, 5'd3, 32'h0000_0088);
                end
                3: begin
                    set_rd(0, 5'd3);
                    set_rd(1, 5'd4);
                    push(K_RD0, 32'd0, "rm_r3_after");
                    push(K_RD1, 32'd0, "rm_r4_after");
                    push(K_RB1, 32'd0, "rm_r4_busy_after");
                    push(K_BV, 32'd0, "rm_vec_after");
                    push(K_NB_BV, 32'd0, "rm_vec_after_nb");
                end
                default: begin
                    set_rd(0, 5'd12);
                    set_rd(1, 5'd7);
                    push(K_RD0, 32'd0, "rm_r12_after");
                    push(K_RD1, 32'd0, "rm_r7_after");
                end
            endcase
            #1;
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_checks++;
                if (observe(e.kind) !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", e.name, observe(e.kind), e.val);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [31:0] mem [32];
        logic [31:0] bsy;
        logic [4:0]  a;
        logic [4:0]  wa [2];
        logic [31:0] wd [2];
        logic [1:0]  we;
        logic [31:0] v;
        logic        hit;
        logic        ie;
        logic [4:0]  ia;
        for (int r = 0; r < 32; r++) mem[r] = 32'd0;
        bsy = 32'd0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            idle();
            we = 2'($urandom_range(0, 3));
            for (int j = 0; j < 2; j++) begin
                wa[j] = rnd_addr();
                wd[j] = $urandom();
                set_wr(j, we[j], wa[j], wd[j]);
            end
            ie       = 1'($urandom_range(0, 1));
            ia       = rnd_addr();
            iss_en   = ie;
            iss_addr = ia;
            for (int k = 0; k < 2; k++) begin
                a = rnd_addr();
                set_rd(k, a);
                v   = mem[a];
                hit = 1'b0;
                for (int j = 0; j < 2; j++) begin
                    if (we[j] && wa[j] == a) begin
                        v   = wd[j];
                        hit = 1'b1;
                    end
                end
                push(K_RD0 + k, (a == 5'd0) ? 32'd0 : v, "rand_rd");
                push(K_RB0 + k, {31'd0, (a != 5'd0) && bsy[a] && !hit}, "rand_busy");
                if (k == 0) begin
                    push(K_NB_RD0, (a == 5'd0) ? 32'd0 : mem[a], "rand_rd_nb");
                    push(K_NB_RB0, {31'd0, bsy[a]}, "rand_busy_nb");
                end
            end
            push(K_BV, bsy, "rand_busy_vec");
            push(K_NB_BV, bsy, "rand_busy_vec_nb");
            #1;
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_checks++;
                if (observe(e.kind) !== e.val) begin
                    n_fail++;
                    $display("FAIL %s (cycle %0d): got %h expected %h", e.name, c, observe(e.kind), e.val);
                end
            end
            for (int j = 0; j < 2; j++) begin
                if (we[j] && wa[j] != 5'd0) mem[wa[j]] = wd[j];
            end
            for (int j = 0; j < 2; j++) begin
                if (we[j]) bsy[wa[j]] = 1'b0;
            end
            if (ie) bsy[ia] = 1'b1;
            bsy[0] = 1'b0;
        end
    endtask

    initial begin
        idle();
        reset = 1'b1;
        test_reset();
        test_sweep_reset();
        test_zero_reg();
        test_bypass();
        test_scoreboard();
        test_issue_clear();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/grf_mp.md
Name: grf_mp

Overview:
- Parametrised multi-port general register file for the pipelined MIPS core; successor to the single-write/two-read GRF.
- Provides NUM_RD combinational read ports and NUM_WR synchronous write ports, with optional same-cycle write-to-read bypass.
- Adds a per-register busy scoreboard: set when a producer issues, cleared on its writeback, and reported per read port to the hazard unit.
- Register 0 is hardwired to zero and is never busy.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; register count is 2**ADDR_W.
- NUM_RD, 2, number of read ports.
- NUM_WR, 1, number of write ports; port index NUM_WR-1 has the highest priority.
- BYPASS, 1, 1 = write data is forwarded to a same-cycle read; 0 = pure registered read.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data, combinational.
- rd_busy  out  NUM_RD  1 = addressed register has a pending producer.
- wr_en  in  NUM_WR  write enables.
- wr_addr  in  NUM_WR*ADDR_W  write addresses.
- wr_data  in  NUM_WR*DATA_W  write data.
- iss_en  in  1  producer issue strobe.
- iss_addr  in  ADDR_W  destination register of the issuing producer.
- busy_vec  out  2**ADDR_W  full scoreboard, for debug and the hazard unit.

Behaviour:
- Reset (synchronous, active-high):
  - All registers and all busy bits are 0 at the next edge.
  - Reset dominates any wr_en or iss_en in the same cycle.
  - After reset, rd_data = 0, rd_busy = 0 and busy_vec = 0 for every port.
- Write:
  - On each posedge with wr_en[j] = 1 and wr_addr[j] != 0, the register at wr_addr[j] takes wr_data[j].
  - Writes to register 0 are ignored.
  - If several enabled write ports target the same address, the highest port index wins. The other ports writing distinct addresses still commit.
- Read (combinational, zero latency):
  - Address 0 always returns 0, with or without bypass.
  - With BYPASS = 1, when addr != 0 and some wr_en[j] has wr_addr[j] == addr, rd_data returns that wr_data[j], using the highest matching j. Otherwise it returns the stored value.
  - With BYPASS = 0, rd_data always returns the stored value; new data is visible from the cycle after the write.
- Scoreboard, evaluated per register r != 0 at each posedge:
  - set = iss_en && iss_addr == r.
  - clr = any wr_en[j] with wr_addr[j] == r.
  - set = 1 → busy[r] = 1; issue wins over a simultaneous clear because a newer producer is pending.
  - set = 0, clr = 1 → busy[r] = 0.
  - Otherwise busy[r] holds.
  - busy[0] is constant 0; iss_addr = 0 is ignored.
- rd_busy[k] = busy[rd_addr[k]] from the current state:
  - With BYPASS = 1, it reads 0 when a same-cycle write to that address is present and bypass supplies the data.
  - Exception: a same-cycle issue does not affect rd_busy until the next cycle.
- A write to a register that is not busy is legal: the data commits and busy stays 0.
- Unknown-free: no read path may return X after reset, for any address.

Test Plan:
- Reset then sweep: write r1..r31 = 0x1000_0000 + r, assert reset for one cycle alongside a write of r5 = 0xFFFF_FFFF → every rd_data reads 0, busy_vec = 0.
- Zero register: wr_en = 1, wr_addr = 0, wr_data = 0xDEAD_BEEF, rd_addr = 0 in the same and next cycles → rd_data = 0 and rd_busy = 0 in both cycles.
- Bypass, NUM_WR = 2: port0 writes r7 = 0x1111_1111 and port1 writes r7 = 0x2222_2222 in the same cycle, reading r7 → rd_data = 0x2222_2222 that cycle and after the edge. With BYPASS = 0 the same cycle returns the old value 0.
- Scoreboard lifecycle: iss r9 at cycle 0 → rd_busy = 1 from cycle 1. Write r9 = 0x55 at cycle 3 → rd_busy = 0 with rd_data = 0x55 (bypass) during cycle 3, and busy_vec[9] = 0 from cycle 4.
- Simultaneous issue and clear: r12 busy; in one cycle iss r12 and write r12 = 0xABCD → r12 = 0xABCD and busy_vec[12] = 1 afterwards.
- Reset mid-operation: r3 busy holding 0x77; assert reset together with a write of r3 = 0x88 and an issue of r4 → r3 = 0, r4 = 0, busy_vec = 0 after the edge.
